mat_load_ctrl: RTL and testbench
================================

MAT_LOAD_CTRL -- requirements
Module: mat_load_ctrl

Interface
REQ-001 Parameter N_ELEM, default 288, elements per frame (operand matrix size).
REQ-002 Parameter ADDR_W, default 9, element index width; 2**ADDR_W SHALL be >= N_ELEM.
REQ-003 Parameter DATA_W, default 8, element width.
REQ-004 Clocking: one clock; reset is synchronous and active-low.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst_n  in  1  synchronous active-low reset.
REQ-007 s_valid  in  1  source element valid.
REQ-008 s_ready  out  1  controller accepts element.
REQ-009 s_data  in  DATA_W  element value.
REQ-010 s_last  in  1  source marks final element of frame.
REQ-011 wr_en  out  1  one-cycle write strobe to operand register bank.
REQ-012 wr_addr  out  ADDR_W  element index 0..N_ELEM-1.
REQ-013 wr_data  out  DATA_W  element value to write.
REQ-014 mult_start  out  1  one-cycle pulse: frame complete, multiplier may start.
REQ-015 mult_done  in  1  multiplier finished with current operands.
REQ-016 busy  out  1  frame partially loaded or multiplier running.
REQ-017 len_err  out  1  one-cycle pulse: s_last disagrees with element count.

Function
REQ-018 States: LOAD, KICK, WAIT; state and index idx (ADDR_W bits) are registers.
REQ-019 Handshake: transfer occurs in a cycle where s_valid=1 and s_ready=1; s_ready SHALL depend only on registered state (no s_valid path).
REQ-020 s_ready=1 in LOAD only; 0 in KICK and WAIT.
REQ-021 On transfer: next cycle wr_en=1, wr_addr=idx at transfer, wr_data=s_data at transfer; otherwise wr_en=0, wr_addr/wr_data hold.
REQ-022 Transfer with idx<N_ELEM-1 and s_last=0: idx<=idx+1, stay LOAD.
REQ-023 Transfer with idx=N_ELEM-1: idx<=0, LOAD->KICK; idx SHALL never reach N_ELEM (no binary wrap at 2**ADDR_W).
REQ-024 Transfer with idx=N_ELEM-1 and s_last=0: len_err pulse next cycle, frame still proceeds to KICK.
REQ-025 Transfer with idx<N_ELEM-1 and s_last=1: element written, len_err pulse next cycle, idx<=0, stay LOAD, no mult_start (frame discarded).
REQ-026 KICK: mult_start=1 for exactly that one cycle, then KICK->WAIT unconditionally.
REQ-027 WAIT: on mult_done=1 -> LOAD next cycle; s_ready rises the cycle after mult_done is sampled.
REQ-028 mult_done in LOAD or KICK SHALL be ignored (no state change, no error).
REQ-029 busy = (state!=LOAD) or (idx!=0), registered-state decode.
REQ-030 Minimum frame period: N_ELEM+2 cycles plus multiplier latency; back-to-back frames with s_valid held high SHALL lose no element.

Reset
REQ-031 rst_n=0 at a rising edge: state=LOAD, idx=0, wr_en=0, wr_addr=0, wr_data=0, mult_start=0, len_err=0.
REQ-032 Reset mid-frame or in WAIT discards partial frame; no mult_start or wr_en issued in the cycle after reset release.
REQ-033 s_ready=1 in the first cycle after reset release.

Structure
REQ-034 Shared package holds N_ELEM, ADDR_W, DATA_W defaults and the state enumeration type.
REQ-035 Index counter with terminal-count detect and clear SHALL be one sub-module, elem_counter; FSM and write-port registers remain in mat_load_ctrl.

Verification
REQ-036 Reset, then 288 transfers values 1..288 (255 wraps to 8-bit), s_last on 288th -> wr_addr 0..287 in order, one mult_start 1 cycle after last wr_en, no len_err.
REQ-037 In WAIT hold s_valid=1 for 50 cycles, then mult_done=1 -> s_ready=0 throughout, s_ready=1 the cycle after mult_done, next wr_addr=0.
REQ-038 s_last=1 on element 100 (idx 99) -> len_err pulse, no mult_start, next transfer writes wr_addr=0.
REQ-039 s_last=0 on element 288 -> len_err pulse and mult_start both occur, state reaches WAIT.
REQ-040 rst_n=0 at idx 150, then full 288-element frame -> addressing restarts at 0, exactly one mult_start.
REQ-041 Random s_valid gaps (50%) plus mult_done pulses during LOAD -> mult_done ignored, element count and addresses exact.

Source files
------------

// File: rtl/mat_load_ctrl_pkg.sv
// Shared defaults and FSM state type for the operand-matrix load controller.
package mat_load_ctrl_pkg;

    localparam int unsigned N_ELEM_DEF = 288;
    localparam int unsigned ADDR_W_DEF = 9;
    localparam int unsigned DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_KICK = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

endpackage

// File: rtl/mat_load_ctrl_elem_counter.sv
// Frame element index: counts accepted elements, wraps at N_ELEM-1, clears early on request.
module elem_counter
    import mat_load_ctrl_pkg::*;
#(
    parameter int unsigned N_ELEM = N_ELEM_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc_i,
    input  logic              clr_i,
    output logic [ADDR_W-1:0] cnt_o,
    output logic              tc_o
);

    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] cnt_d;

    assign tc_o  = (cnt_q == ADDR_W'(N_ELEM - 1));
    assign cnt_o = cnt_q;

    // Explicit terminal-count wrap keeps the index inside 0..N_ELEM-1.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i) begin
            if (clr_i || tc_o) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mat_load_ctrl.sv
// Streams one frame of operand elements into the register bank, then kicks the
// multiplier and waits for it to finish before accepting the next frame.
module mat_load_ctrl
    import mat_load_ctrl_pkg::*;
#(
    parameter int unsigned N_ELEM = N_ELEM_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              mult_start,
    input  logic              mult_done,
    output logic              busy,
    output logic              len_err
);

    state_e            state_q;
    state_e            state_d;
    logic              xfer;
    logic [ADDR_W-1:0] idx;
    logic              idx_tc;

    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic              mult_start_q;
    logic              len_err_q;

    assign s_ready = (state_q == ST_LOAD);
    assign xfer    = s_valid & s_ready;

    elem_counter #(
        .N_ELEM (N_ELEM),
        .ADDR_W (ADDR_W)
    ) u_elem_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (xfer),
        .clr_i (s_last),
        .cnt_o (idx),
        .tc_o  (idx_tc)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD: if (xfer && idx_tc) state_d = ST_KICK;
            ST_KICK: state_d = ST_WAIT;
            ST_WAIT: if (mult_done) state_d = ST_LOAD;
            default: state_d = ST_LOAD;
        endcase
    end

    // mult_start is registered off KICK, so it lands one cycle after the final write strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_LOAD;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            mult_start_q <= 1'b0;
            len_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_en_q      <= xfer;
            mult_start_q <= (state_q == ST_KICK);
            len_err_q    <= xfer & (idx_tc ^ s_last);
            if (xfer) begin
                wr_addr_q <= idx;
                wr_data_q <= s_data;
            end
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign mult_start = mult_start_q;
    assign len_err    = len_err_q;
    assign busy       = (state_q != ST_LOAD) || (idx != '0);

endmodule

// File: tb/tb_mat_load_ctrl.sv
// Directed bench for mat_load_ctrl with a write-port scoreboard and pulse counters.
module tb_mat_load_ctrl;

    localparam int unsigned N  = 288;
    localparam int unsigned AW = 9;
    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic          s_last = 1'b0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          mult_start;
    logic          mult_done = 1'b0;
    logic          busy;
    logic          len_err;

    int n_cmp = 0;
    int n_err = 0;

    logic [AW+DW-1:0] sb[$];
    int unsigned exp_idx = 0;
    int exp_ms = 0;
    int exp_le = 0;
    int ms_cnt = 0;
    int le_cnt = 0;
    int cyc = 0;
    int last_wr_cyc = -10;

    mat_load_ctrl #(
        .N_ELEM (N),
        .ADDR_W (AW),
        .DATA_W (DW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_last     (s_last),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .mult_start (mult_start),
        .mult_done  (mult_done),
        .busy       (busy),
        .len_err    (len_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            if (sb.size() == 0) begin
                chk("wr_unexpected", 32'(wr_en), 32'd0);
            end else begin
                logic [AW+DW-1:0] e;
                e = sb.pop_front();
                chk("wr_addr", 32'(wr_addr), 32'(e[AW+DW-1:DW]));
                chk("wr_data", 32'(wr_data), 32'(e[DW-1:0]));
            end
            if (wr_addr == AW'(N - 1)) last_wr_cyc = cyc;
        end
        if (mult_start === 1'b1) begin
            ms_cnt++;
            chk("mult_start_lat", 32'(cyc), 32'(last_wr_cyc + 1));
        end
        if (len_err === 1'b1) le_cnt++;
    end

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    // Leaves s_valid asserted on return so consecutive calls stream back-to-back.
    task automatic send(input logic [DW-1:0] d, input logic last);
        logic acc;
        int   budget;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        budget  = 2000;
        acc     = 1'b0;
        while (!acc && budget > 0) begin
            acc = s_ready;
            clk1();
            budget--;
        end
        if (!acc) begin
            chk("send_timeout", 32'(s_ready), 32'd1);
        end else begin
            sb.push_back({AW'(exp_idx), d});
            if (exp_idx == N - 1) begin
                exp_idx = 0;
                exp_ms++;
                if (!last) exp_le++;
            end else if (last) begin
                exp_idx = 0;
                exp_le++;
            end else begin
                exp_idx++;
            end
        end
    endtask

    task automatic done_pulse();
        mult_done = 1'b1;
        clk1();
        mult_done = 1'b0;
    endtask

    initial begin
        int unsigned v;
        // Reset state
        rst_n = 1'b0;
        repeat (3) clk1();
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_mult_start", 32'(mult_start), 32'd0);
        chk("rst_len_err", 32'(len_err), 32'd0);
        rst_n = 1'b1;
        clk1();
        chk("rel_s_ready", 32'(s_ready), 32'd1);
        chk("rel_busy", 32'(busy), 32'd0);

        // Full frame 1..288, s_last on element 288, streamed back-to-back
        for (int i = 1; i <= int'(N); i++) begin
            v = i;
            send(DW'(v), i == int'(N));
            if (i == 10) chk("mid_busy", 32'(busy), 32'd1);
        end

        // Hold s_valid in WAIT: s_ready stays low until mult_done
        s_data = 8'hA5;
        s_last = 1'b0;
        for (int i = 0; i < 50; i++) begin
            clk1();
            chk("wait_s_ready", 32'(s_ready), 32'd0);
        end
        chk("f1_mult_start_cnt", 32'(ms_cnt), 32'd1);
        chk("f1_len_err_cnt", 32'(le_cnt), 32'd0);
        chk("wait_busy", 32'(busy), 32'd1);
        done_pulse();
        chk("done_s_ready", 32'(s_ready), 32'd1);
        send(8'hA5, 1'b0);

        // Early s_last on element 100 discards the frame
        for (int i = 2; i <= 100; i++) begin
            v = i + 7;
            send(DW'(v), i == 100);
        end
        s_valid = 1'b0;
        repeat (4) clk1();
        chk("short_len_err_cnt", 32'(le_cnt), 32'(exp_le));
        chk("short_mult_start_cnt", 32'(ms_cnt), 32'd1);
        chk("short_s_ready", 32'(s_ready), 32'd1);
        chk("short_busy", 32'(busy), 32'd0);

        // Full frame with s_last missing on element 288
        for (int i = 0; i < int'(N); i++) begin
            v = i * 3;
            send(DW'(v), 1'b0);
        end
        s_valid = 1'b0;
        repeat (4) clk1();
        chk("nolast_len_err_cnt", 32'(le_cnt), 32'd2);
        chk("nolast_mult_start_cnt", 32'(ms_cnt), 32'd2);
        chk("nolast_in_wait", 32'(s_ready), 32'd0);
        done_pulse();

        // Reset at idx 150, then a clean frame
        for (int i = 0; i < 150; i++) begin
            v = i ^ 32'h5A;
            send(DW'(v), 1'b0);
        end
        s_valid = 1'b0;
        rst_n = 1'b0;
        exp_idx = 0;
        repeat (2) clk1();
        rst_n = 1'b1;
        clk1();
        chk("prst_wr_en", 32'(wr_en), 32'd0);
        chk("prst_mult_start", 32'(mult_start), 32'd0);
        chk("prst_busy", 32'(busy), 32'd0);
        for (int i = 0; i < int'(N); i++) begin
            v = i + 40;
            send(DW'(v), i == int'(N) - 1);
        end
        s_valid = 1'b0;
        repeat (4) clk1();
        chk("prst_mult_start_cnt", 32'(ms_cnt), 32'd3);
        done_pulse();

        // Random valid gaps with stray mult_done pulses during LOAD
        for (int i = 0; i < int'(N); i++) begin
            repeat ($urandom_range(0, 2)) begin
                s_valid   = 1'b0;
                mult_done = 1'($urandom_range(0, 1));
                clk1();
            end
            mult_done = 1'b0;
            v = $urandom;
            send(DW'(v), i == int'(N) - 1);
        end
        s_valid = 1'b0;
        repeat (4) clk1();
        chk("rnd_mult_start_cnt", 32'(ms_cnt), 32'(exp_ms));
        chk("rnd_in_wait", 32'(s_ready), 32'd0);
        done_pulse();
        repeat (2) clk1();

        chk("total_len_err", 32'(le_cnt), 32'(exp_le));
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
